// File: rtl/sync_fifo_if.sv
// Handshake bundle between a producer/consumer pair and sync_fifo.
// The master side pushes and pops; the slave side is the FIFO itself.
interface sync_fifo_if #(
  parameter int DATA_BITS = 11
);
  logic [DATA_BITS-1:0] input_data;
  logic                 write;
  logic                 read;
  logic [DATA_BITS-1:0] output_data;
  logic                 empty;
  logic                 full;

  modport master (
    output input_data,
    output write,
    output read,
    input  output_data,
    input  empty,
    input  full
  );

  modport slave (
    input  input_data,
    input  write,
    input  read,
    output output_data,
    output empty,
    output full
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO. The oldest stored word is always presented
// on output_data (zero when empty). Flags and head data are decoded from
// registers only, so a consumer may form read combinationally from them.
module sync_fifo #(
  parameter int DATA_BITS   = 11,
  parameter int FIFO_LENGTH = 16
) (
  input logic        clk,
  input logic        reset,
  sync_fifo_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_LENGTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_LENGTH);

  logic [DATA_BITS-1:0] mem [FIFO_LENGTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 empty_int;
  logic                 full_int;
  logic                 write_ok;
  logic                 read_ok;

  assign empty_int = (count == '0);
  assign full_int  = (count == FULL_COUNT);

  // A write while full and a read while empty are silently discarded.
  assign write_ok = bus.write & ~full_int;
  assign read_ok  = bus.read  & ~empty_int;

  // Storage array; not cleared by reset, and a write in a reset cycle is
  // blocked so the discarded word never lands in memory.
  always_ff @(posedge clk) begin
    if (write_ok && !reset) begin
      mem[wr_ptr] <= bus.input_data;
    end
  end

  // Write pointer, wraps naturally at FIFO_LENGTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
    end else if (write_ok) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // Read pointer, wraps naturally at FIFO_LENGTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
    end else if (read_ok) begin
      rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Occupancy: a simultaneous accepted push and pop leave it unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      case ({write_ok, read_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head word and status flags, decoded from registered state only.
  always_comb begin
    bus.output_data = '0;
    if (!empty_int) begin
      bus.output_data = mem[rd_ptr];
    end
    bus.empty = empty_int;
    bus.full  = full_int;
  end
endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: queue scoreboard of pushed words, compared on pop.
module tb_sync_fifo;
  localparam int DATA_BITS   = 11;
  localparam int FIFO_LENGTH = 16;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [DATA_BITS-1:0] q[$];

  sync_fifo_if #(.DATA_BITS(DATA_BITS)) bus ();

  sync_fifo #(.DATA_BITS(DATA_BITS), .FIFO_LENGTH(FIFO_LENGTH)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle, update the scoreboard; returns the word seen on pop.
  task automatic cycle(input logic w, input logic r, input logic [DATA_BITS-1:0] d,
                       output logic popped, output logic [DATA_BITS-1:0] got,
                       output logic [DATA_BITS-1:0] exp);
    logic wok, rok;
    bus.write      = w;
    bus.read       = r;
    bus.input_data = d;
    wok    = w && (q.size() < FIFO_LENGTH);
    rok    = r && (q.size() > 0);
    popped = rok;
    got    = bus.output_data;
    exp    = rok ? q[0] : '0;
    @(posedge clk);
    #1;
    if (rok) void'(q.pop_front());
    if (wok) q.push_back(d);
    bus.write = 1'b0;
    bus.read  = 1'b0;
  endtask

  task automatic reset_fifo();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
  endtask

  task automatic test_reset();
    logic p;
    logic [DATA_BITS-1:0] g, e;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.output_data !== '0) begin
        errors++;
        $display("FAIL reset_state: empty=%b full=%b data=%h, required empty=1 full=0 data=000",
                 bus.empty, bus.full, bus.output_data);
      end
    end
    reset = 1'b0;
    q.delete();
    cycle(1'b0, 1'b1, '0, p, g, e);
    checks++;
    if (bus.empty !== 1'b1 || bus.output_data !== '0) begin
      errors++;
      $display("FAIL read_when_empty: empty=%b data=%h, required empty=1 data=000",
               bus.empty, bus.output_data);
    end
  endtask

  task automatic test_single_word();
    logic p;
    logic [DATA_BITS-1:0] g, e;
    reset_fifo();
    cycle(1'b1, 1'b0, 11'h005, p, g, e);
    checks++;
    if (bus.output_data !== 11'h005 || bus.empty !== 1'b0) begin
      errors++;
      $display("FAIL single_latency: data=%h empty=%b, required data=005 empty=0",
               bus.output_data, bus.empty);
    end
    cycle(1'b0, 1'b1, '0, p, g, e);
    checks++;
    if (g !== 11'h005) begin
      errors++;
      $display("FAIL single_pop_data: got %h, required 005", g);
    end
    checks++;
    if (bus.empty !== 1'b1 || bus.output_data !== '0) begin
      errors++;
      $display("FAIL single_after_pop: empty=%b data=%h, required empty=1 data=000",
               bus.empty, bus.output_data);
    end
  endtask

  task automatic test_stream();
    logic p;
    logic [DATA_BITS-1:0] g, e;
    int pops;
    int full_seen;
    int order_err;
    pops = 0;
    full_seen = 0;
    order_err = 0;
    reset_fifo();
    for (int i = 0; i < 33; i++) begin
      if (i < 10)       cycle(1'b1, !bus.empty, DATA_BITS'(i), p, g, e);
      else if (i == 10) cycle(1'b0, !bus.empty, '0, p, g, e);
      else if (i < 21)  cycle(1'b1, !bus.empty, DATA_BITS'(i - 6), p, g, e);
      else              cycle(1'b0, !bus.empty, '0, p, g, e);
      if (p) begin
        // Independent expected sequence: 0..9 then 5..14.
        if (g !== e || g !== DATA_BITS'(pops < 10 ? pops : pops - 5)) order_err++;
        pops++;
      end
      if (bus.full !== 1'b0) full_seen++;
    end
    checks++;
    if (order_err != 0) begin
      errors++;
      $display("FAIL stream_order: %0d out-of-order words, required 0", order_err);
    end
    checks++;
    if (pops != 20) begin
      errors++;
      $display("FAIL stream_count: popped %0d words, required 20", pops);
    end
    checks++;
    if (full_seen != 0) begin
      errors++;
      $display("FAIL stream_full: full high in %0d cycles, required 0", full_seen);
    end
    checks++;
    if (bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL stream_drained: empty=%b, required 1", bus.empty);
    end
  endtask

  task automatic test_fill_overflow();
    logic p;
    logic [DATA_BITS-1:0] g, e;
    int bad;
    bad = 0;
    reset_fifo();
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 1'b0, DATA_BITS'(11'h100 + i), p, g, e);
      if (i < 15 && bus.full !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL early_full: full high %0d times before 16th write, required 0", bad);
    end
    checks++;
    if (bus.full !== 1'b1 || bus.empty !== 1'b0) begin
      errors++;
      $display("FAIL full_flag: full=%b empty=%b, required full=1 empty=0", bus.full, bus.empty);
    end
    cycle(1'b1, 1'b0, 11'h7FF, p, g, e);
    checks++;
    if (bus.full !== 1'b1 || bus.output_data !== 11'h100) begin
      errors++;
      $display("FAIL overflow_hold: full=%b head=%h, required full=1 head=100",
               bus.full, bus.output_data);
    end
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b1, '0, p, g, e);
      if (!p || g !== e || g !== DATA_BITS'(11'h100 + i)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL drain_order: %0d wrong words, required 0", bad);
    end
    checks++;
    if (bus.empty !== 1'b1 || bus.output_data !== '0 || bus.full !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty: empty=%b full=%b data=%h, required 1 0 000",
               bus.empty, bus.full, bus.output_data);
    end
  endtask

  task automatic test_back_to_back();
    logic p;
    logic [DATA_BITS-1:0] g, e;
    int flag_err;
    int data_err;
    flag_err = 0;
    data_err = 0;
    reset_fifo();
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, DATA_BITS'(11'h200 + i), p, g, e);
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 1'b1, DATA_BITS'(11'h208 + i), p, g, e);
      if (!p || g !== e || g !== DATA_BITS'(11'h200 + i)) data_err++;
      if (bus.full !== 1'b0 || bus.empty !== 1'b0) flag_err++;
    end
    checks++;
    if (data_err != 0) begin
      errors++;
      $display("FAIL wrap_order: %0d wrong words, required 0", data_err);
    end
    checks++;
    if (flag_err != 0) begin
      errors++;
      $display("FAIL wrap_flags: %0d bad flag cycles, required 0", flag_err);
    end
    data_err = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, '0, p, g, e);
      if (!p || g !== DATA_BITS'(11'h228 + i)) data_err++;
    end
    checks++;
    if (data_err != 0 || bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL wrap_occupancy: %0d wrong words empty=%b, required 0 words and empty=1",
               data_err, bus.empty);
    end
  endtask

  task automatic test_reset_midop();
    logic p;
    logic [DATA_BITS-1:0] g, e;
    reset_fifo();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, DATA_BITS'(11'h300 + i), p, g, e);
    reset          = 1'b1;
    bus.write      = 1'b1;
    bus.input_data = 11'h3AA;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    bus.write = 1'b0;
    q.delete();
    checks++;
    if (bus.empty !== 1'b1 || bus.output_data !== '0 || bus.full !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset: empty=%b full=%b data=%h, required 1 0 000",
               bus.empty, bus.full, bus.output_data);
    end
    cycle(1'b0, 1'b0, '0, p, g, e);
    checks++;
    if (bus.empty !== 1'b1 || bus.output_data !== '0) begin
      errors++;
      $display("FAIL midop_write_dropped: empty=%b data=%h, required empty=1 data=000",
               bus.empty, bus.output_data);
    end
    cycle(1'b1, 1'b0, 11'h0AB, p, g, e);
    checks++;
    if (bus.output_data !== 11'h0AB || bus.empty !== 1'b0) begin
      errors++;
      $display("FAIL midop_recover: data=%h empty=%b, required data=0ab empty=0",
               bus.output_data, bus.empty);
    end
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    reset          = 1'b1;
    bus.write      = 1'b0;
    bus.read       = 1'b0;
    bus.input_data = '0;
    test_reset();
    test_single_word();
    test_stream();
    test_fill_overflow();
    test_back_to_back();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
